uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel receiver for the board's RS-232 link, the companion to the existing frame transmitter. Samples the asynchronous `Rxd` line, recovers one 8N1 frame (start, 8 data LSB-first, stop) at the same bit period as the transmitter, and presents it as a 10-bit frame plus data byte behind a one-deep `rdy`/`ack` buffer. The 10-bit frame uses the transmitter's frame layout, so a received frame can be looped straight back to the transmitter.

## Interface
- `CLKS_PER_BIT`, 10416, clk cycles per bit (100 MHz / 9600 baud); legal values ≥ 4.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `Rxd`  in  1  asynchronous serial line; idles high.
- `ack`  in  1  consumer acknowledge; drives transmitter `rdy`-style handshake.
- `frame`  out  10  bit0 = start (0), bits 8:1 = data, bit9 = sampled stop.
- `data`  out  8  received byte (= `frame[8:1]`).
- `rdy`  out  1  buffer holds an unconsumed frame.
- `ferr`  out  1  framing error for the buffered frame (stop sampled 0).
- `overrun`  out  1  a frame was overwritten before `ack`; sticky until `ack`.

## Operation
- Input sync: 2-FF synchronizer, both flops reset to 1; the FSM uses only `rxd_s`.
- `HALF = CLKS_PER_BIT/2` (floor). `div` width = clog2(CLKS_PER_BIT); `bitcnt` is 3 bits.
- States:
  - IDLE: on `rxd_s==0`, go to START with `div=0`.
  - START: `div++`; at `div==HALF-1`, if `rxd_s==0` go to DATA with `div=0`, `bitcnt=0`; otherwise treat it as a glitch and return to IDLE.
  - DATA: `div++`; at `div==CLKS_PER_BIT-1`, set `shift[bitcnt]=rxd_s`, `div=0`, `bitcnt++`; after bit 7, go to STOP.
  - STOP: at `div==CLKS_PER_BIT-1`, sample the stop bit and load the buffer. Go to IDLE if stop = 1, else to BREAK.
  - BREAK: wait for `rxd_s==1`, then go to IDLE. No new start is detected while the line is held low.
- Buffer load (STOP completion cycle):
  - `frame <= {stop, shift, 1'b0}`, `data <= shift`, `ferr <= ~stop`, `rdy <= 1`.
  - Overrun: if `rdy==1` and `ack==0` in that cycle, set `overrun <= 1`. The new frame overwrites the old one.
- Handshake: when `ack==1` and `rdy==1` on an edge with no load, clear `rdy` and `overrun` on the next edge. `ack` while `rdy==0` is ignored.
- Simultaneous `ack` and load: the load wins. `rdy` stays 1, `overrun` is cleared, and the old frame is treated as consumed.
- Reset values: `frame=10'h3FF`, `data=0`, `rdy=0`, `ferr=0`, `overrun=0`, state IDLE, `div=0`, `bitcnt=0`, sync flops 1.
- Reset mid-frame aborts the frame with no partial output. The next falling edge starts a fresh frame.

## Timing
- Let Ein be the edge at which the first sync flop captures `Rxd==0`. The FSM leaves IDLE at Ein+2.
- Bit samples:
  - start check at Ein+2+HALF;
  - data bit k (k=0..7) at Ein+2+HALF+(k+1)·CLKS_PER_BIT;
  - stop at Ein+2+HALF+9·CLKS_PER_BIT.
- `rdy` is high after the stop-sample edge. Total latency is 2+HALF+9·CLKS_PER_BIT cycles (CLKS_PER_BIT=16 gives 154).
- `rdy` falls one cycle after the `ack` edge.
- Back-to-back frames are accepted: the receiver is in IDLE one cycle after the stop sample, well inside the stop bit.

## Structure
- Shared package `uart_pkg`:
  - `CLKS_PER_BIT_DEFAULT = 10416`;
  - frame bit positions `START_BIT = 0`, `STOP_BIT = 9`;
  - the state enum (IDLE, START, DATA, STOP, BREAK). The transmitter is to adopt the same constants.
- One sub-module, `uart_rx_sync`: the 2-FF synchronizer with reset-to-1, reusable for other asynchronous inputs.
- Everything else is one sequential process plus output registers.

## Test plan
All scenarios use `CLKS_PER_BIT=16`.
- Send 0xA5 with a valid stop bit → `rdy` rises 154 cycles after Ein; `frame=10'b1_10100101_0`, `data=8'hA5`, `ferr=0`, `overrun=0`.
- `Rxd` low for 3 cycles, then high → no `rdy`; FSM back in IDLE; a following 0x5A frame is received correctly.
- Send 0x00 with stop=0, `Rxd` held low 40 more bit-times → one frame with `ferr=1`, `frame[9]=0`, and no second frame until `Rxd` returns high.
- Send 0x11 then 0x22 back-to-back, `ack=0` → `data=8'h22`, `overrun=1`. Pulse `ack` → `rdy=0`, `overrun=0` on the next cycle.
- Hold `ack=1` continuously and send 0x33 then 0x44 → each frame loads with `rdy=1` and `overrun` stays 0.
- Assert `rst` during data bit 4 of a frame → all outputs at reset values, no `rdy`. Send 0x3C next → received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants, frame layout and receiver state encoding.
// The frame transmitter is expected to import the same definitions.
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 10416;

   localparam int unsigned START_BIT = 0;
   localparam int unsigned STOP_BIT  = 9;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input that idles high.
// Both flops reset to 1 so a held reset never looks like a start bit.
module uart_rx_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 serial receiver with a one-deep rdy/ack output buffer.
// Frames use the transmitter layout so they can be looped straight back.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Rxd,
   input  logic       ack,
   output logic [9:0] frame,
   output logic [7:0] data,
   output logic       rdy,
   output logic       ferr,
   output logic       overrun
);

   localparam int unsigned DivW = $clog2(CLKS_PER_BIT);
   localparam int unsigned Half = CLKS_PER_BIT / 2;
   localparam logic [DivW-1:0] DivLast = DivW'(CLKS_PER_BIT - 1);
   localparam logic [DivW-1:0] DivHalf = DivW'(Half - 1);

   logic            rxd_s;
   rx_state_e       state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            load;

   logic [9:0]      frame_q, frame_d;
   logic [7:0]      data_q, data_d;
   logic            rdy_q, rdy_d;
   logic            ferr_q, ferr_d;
   logic            overrun_q, overrun_d;

   uart_rx_sync u_rx_sync (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (Rxd),
      .q_o   (rxd_s)
   );

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      load     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rxd_s) begin
               state_d = StStart;
               div_d   = '0;
            end
         end
         StStart: begin
            if (div_q == DivHalf) begin
               div_d = '0;
               // A start bit that is already gone at mid-bit was only a glitch.
               if (!rxd_s) begin
                  state_d  = StData;
                  bitcnt_d = '0;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StData: begin
            if (div_q == DivLast) begin
               div_d            = '0;
               shift_d[bitcnt_q] = rxd_s;
               bitcnt_d         = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  state_d = StStop;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StStop: begin
            if (div_q == DivLast) begin
               div_d   = '0;
               load    = 1'b1;
               state_d = rxd_s ? StIdle : StBreak;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StBreak: begin
            if (rxd_s) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      frame_d   = frame_q;
      data_d    = data_q;
      rdy_d     = rdy_q;
      ferr_d    = ferr_q;
      overrun_d = overrun_q;
      if (load) begin
         frame_d[STOP_BIT]  = rxd_s;
         frame_d[8:1]       = shift_q;
         frame_d[START_BIT] = 1'b0;
         data_d             = shift_q;
         ferr_d             = ~rxd_s;
         rdy_d              = 1'b1;
         // A concurrent ack consumes the old frame, so only an unacked one is lost.
         if (ack) begin
            overrun_d = 1'b0;
         end else if (rdy_q) begin
            overrun_d = 1'b1;
         end
      end else if (ack && rdy_q) begin
         rdy_d     = 1'b0;
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         div_q     <= '0;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         frame_q   <= 10'h3FF;
         data_q    <= '0;
         rdy_q     <= 1'b0;
         ferr_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bitcnt_q  <= bitcnt_d;
         shift_q   <= shift_d;
         frame_q   <= frame_d;
         data_q    <= data_d;
         rdy_q     <= rdy_d;
         ferr_q    <= ferr_d;
         overrun_q <= overrun_d;
      end
   end

   assign frame   = frame_q;
   assign data    = data_q;
   assign rdy     = rdy_q;
   assign ferr    = ferr_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 16 clocks per bit.
// Stimulus pushes expected frames; a monitor pops and compares on each new presentation.
module tb_uart_receiver;

   localparam int unsigned Cpb = 16;
   localparam int Latency = 2 + Cpb / 2 + 9 * Cpb;

   typedef struct packed {
      logic [9:0] frame;
      logic       ferr;
      logic       ov;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       Rxd;
   logic       ack;
   logic [9:0] frame;
   logic [7:0] data;
   logic       rdy;
   logic       ferr;
   logic       overrun;

   int   total;
   int   bad;
   exp_t sbq[$];

   uart_receiver #(
      .CLKS_PER_BIT (Cpb)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .Rxd     (Rxd),
      .ack     (ack),
      .frame   (frame),
      .data    (data),
      .rdy     (rdy),
      .ferr    (ferr),
      .overrun (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic stop, input logic ov);
      exp_t e;
      e.frame = {stop, d, 1'b0};
      e.ferr  = ~stop;
      e.ov    = ov;
      sbq.push_back(e);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Drives a full frame; lat is the edge count from Ein to rdy rising, or -1.
   task automatic send_frame(input logic [7:0] d, input logic stop, output int lat);
      logic [9:0] f;
      logic       rdy0;
      int         cnt;
      f    = {stop, d, 1'b0};
      rdy0 = rdy;
      lat  = -1;
      cnt  = 0;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < Cpb; c++) begin
            Rxd = f[i];
            @(negedge clk);
            cnt++;
            if (lat < 0 && !rdy0 && rdy) lat = cnt - 1;
         end
      end
      Rxd = 1'b1;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " frame"}, 32'(frame), 32'h3FF);
      chk({tag, " data"}, 32'(data), 32'h0);
      chk({tag, " rdy"}, 32'(rdy), 32'h0);
      chk({tag, " ferr"}, 32'(ferr), 32'h0);
      chk({tag, " overrun"}, 32'(overrun), 32'h0);
   endtask

   // Monitor: a presentation is rdy rising, or a new frame/overrun while rdy stays high.
   initial begin : monitor
      logic [9:0] frame_p;
      logic       rdy_p;
      logic       ov_p;
      exp_t       e;
      frame_p = 10'h3FF;
      rdy_p   = 1'b0;
      ov_p    = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && rdy && (!rdy_p || frame != frame_p || overrun != ov_p)) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected frame: got %0h want none", frame);
            end else begin
               e = sbq.pop_front();
               chk("sb frame", 32'(frame), 32'(e.frame));
               chk("sb data", 32'(data), 32'(e.frame[8:1]));
               chk("sb ferr", 32'(ferr), 32'(e.ferr));
               chk("sb overrun", 32'(overrun), 32'(e.ov));
            end
         end
         frame_p = frame;
         rdy_p   = rdy;
         ov_p    = overrun;
      end
   end

   initial begin : stim
      int lat;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      Rxd   = 1'b1;
      ack   = 1'b0;
      cycles(3);
      chk_reset_vals("reset");
      rst = 1'b0;
      cycles(5);

      // Nominal frame and latency.
      push(8'hA5, 1'b1, 1'b0);
      send_frame(8'hA5, 1'b1, lat);
      chk("latency", 32'(lat), 32'(Latency));
      pulse_ack();
      chk("rdy after ack", 32'(rdy), 32'h0);
      cycles(Cpb);

      // Short low glitch must not produce a frame.
      Rxd = 1'b0;
      cycles(3);
      Rxd = 1'b1;
      cycles(3 * Cpb);
      chk("glitch rdy", 32'(rdy), 32'h0);
      push(8'h5A, 1'b1, 1'b0);
      send_frame(8'h5A, 1'b1, lat);
      pulse_ack();
      cycles(Cpb);

      // Framing error followed by a long break.
      push(8'h00, 1'b0, 1'b0);
      send_frame(8'h00, 1'b0, lat);
      Rxd = 1'b0;
      chk("break frame9", 32'(frame[9]), 32'h0);
      chk("break ferr", 32'(ferr), 32'h1);
      cycles(20);
      pulse_ack();
      cycles(40 * Cpb);
      chk("break no 2nd rdy", 32'(rdy), 32'h0);
      Rxd = 1'b1;
      cycles(2 * Cpb);
      chk("break release rdy", 32'(rdy), 32'h0);

      // Back-to-back without ack overwrites and flags overrun.
      push(8'h11, 1'b1, 1'b0);
      push(8'h22, 1'b1, 1'b1);
      send_frame(8'h11, 1'b1, lat);
      send_frame(8'h22, 1'b1, lat);
      chk("b2b data", 32'(data), 32'h22);
      chk("b2b overrun", 32'(overrun), 32'h1);
      pulse_ack();
      chk("ack clears rdy", 32'(rdy), 32'h0);
      chk("ack clears overrun", 32'(overrun), 32'h0);
      cycles(Cpb);

      // Ack held high: each load presents cleanly, never overrun.
      ack = 1'b1;
      push(8'h33, 1'b1, 1'b0);
      push(8'h44, 1'b1, 1'b0);
      send_frame(8'h33, 1'b1, lat);
      send_frame(8'h44, 1'b1, lat);
      chk("held ack overrun", 32'(overrun), 32'h0);
      ack = 1'b0;
      cycles(Cpb);

      // Reset during data bit 4 aborts the frame.
      begin
         logic [9:0] f;
         f = {1'b1, 8'hC3, 1'b0};
         for (int i = 0; i < 5; i++) begin
            Rxd = f[i];
            cycles(Cpb);
         end
         Rxd = f[5];
         cycles(Cpb / 2);
      end
      rst = 1'b1;
      cycles(2);
      chk_reset_vals("midrst");
      rst = 1'b0;
      Rxd = 1'b1;
      cycles(2 * Cpb);
      chk("midrst no rdy", 32'(rdy), 32'h0);
      push(8'h3C, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, lat);
      chk("post-reset latency", 32'(lat), 32'(Latency));
      pulse_ack();
      cycles(Cpb);

      chk("scoreboard drained", 32'(sbq.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
